seg_scan_driver: RTL and testbench

Time-multiplexed driver for the board's four-digit seven-segment display. Converts a 16-bit binary value (game score) to BCD with a sequential double-dabble converter, applies leading-zero blanking and overflow dashes, and scans the four anodes in turn. Each scan slot presents one 5-bit digit code to the downstream segment mapper. Sits between the game/score logic and the segment mapper.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_scan_driver_if.sv | 24 ++
 rtl/seg_scan_driver_bin2bcd_seq.sv | 75 +++++++
 rtl/seg_scan_driver.sv | 96 +++++++++
 tb/tb_seg_scan_driver.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants, converter state type and the BCD add-3 helper for the
// seven-segment scan driver.
package seg_pkg;

  localparam logic [4:0]  CODE_BLANK  = 5'd16;
  localparam logic [4:0]  CODE_DASH   = 5'd17;
  localparam int          NUM_DIGITS  = 4;
  localparam logic [15:0] MAX_DISPLAY = 16'd9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bundle between the score logic (master) and the scan driver (slave).
interface seg_scan_driver_if;
  import seg_pkg::*;

  // No handshake: value and en are level-sampled every cycle; an, digit_holder
  // and busy are registered and valid on every cycle.
  logic [15:0] value;
  logic        en;
  logic [3:0]  an;
  logic [4:0]  digit_holder;
  logic        busy;
  conv_state_e conv_state;

  modport master (
    output value, en,
    input  an, digit_holder, busy, conv_state
  );

  modport slave (
    input  value, en,
    output an, digit_holder, busy, conv_state
  );

endinterface

// File: rtl/seg_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: 1 capture cycle, 16 shift cycles, 1 done
// cycle, repeating back-to-back.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bin,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic        done,
  output logic        busy,
  output conv_state_e state
);

  conv_state_e state_q;
  logic [3:0]  cnt_q;
  logic [15:0] bin_q;
  logic [15:0] bcd_q;
  logic        ovf_q;
  logic        done_q;
  logic        busy_q;
  logic [31:0] shift_d;

  assign shift_d = {bcd_adjust(bcd_q), bin_q} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      bin_q   <= 16'd0;
      bcd_q   <= 16'd0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bin_q   <= bin;
          bcd_q   <= 16'd0;
          ovf_q   <= (bin > MAX_DISPLAY);
          cnt_q   <= 4'd0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          {bcd_q, bin_q} <= shift_d;
          cnt_q          <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bcd   = bcd_q;
  assign ovf   = ovf_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign state = state_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit seven-segment scan driver: BCD conversion, leading-zero blanking,
// overflow dashes and anode multiplexing with registered outputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter bit LZ_BLANK        = 1'b1
) (
  input logic              clk,
  input logic              rst,
  seg_scan_driver_if.slave bus
);

  localparam int TW = (TICKS_PER_DIGIT > 2) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_DIGIT - 1);

  logic [15:0] bcd;
  logic        ovf;
  logic        conv_done;
  logic        conv_busy;
  conv_state_e conv_state;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .bin   (bus.value),
    .bcd   (bcd),
    .ovf   (ovf),
    .done  (conv_done),
    .busy  (conv_busy),
    .state (conv_state)
  );

  logic [4:0]    disp_q [NUM_DIGITS];
  logic [4:0]    disp_d [NUM_DIGITS];
  logic          lead_zero;
  logic [TW-1:0] tick_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q;
  logic [4:0]    digit_q;

  // Blank from the top down while nibbles stay zero; digit 0 always shows.
  always_comb begin
    lead_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      disp_d[k] = ovf ? CODE_DASH : {1'b0, bcd[4*k +: 4]};
    end
    if (LZ_BLANK && !ovf) begin
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        if (lead_zero && (bcd[4*k +: 4] == 4'd0)) disp_d[k] = CODE_BLANK;
        else                                      lead_zero = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k < NUM_DIGITS; k++) disp_q[k] <= CODE_BLANK;
      disp_q[0] <= 5'd0;
    end else if (conv_done) begin
      for (int k = 0; k < NUM_DIGITS; k++) disp_q[k] <= disp_d[k];
    end
  end

  // Scan position keeps running while disabled so re-enable resumes mid-slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      idx_q  <= 2'd0;
    end else if (tick_q == TICK_MAX) begin
      tick_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      tick_q <= tick_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q    <= 4'b1111;
      digit_q <= CODE_BLANK;
    end else if (bus.en) begin
      an_q    <= ~(4'b0001 << idx_q);
      digit_q <= disp_q[idx_q];
    end else begin
      an_q    <= 4'b1111;
      digit_q <= CODE_BLANK;
    end
  end

  assign bus.an           = an_q;
  assign bus.digit_holder = digit_q;
  assign bus.busy         = conv_busy;
  assign bus.conv_state   = conv_state;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a decimal-arithmetic reference model
// predicts every output cycle for a blanking and a non-blanking instance.
module tb_seg_scan_driver;
  import seg_pkg::*;

  localparam int T = 4;
  localparam int W = 10;
  localparam int PERIOD = 18;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        en;

  always #5 clk = ~clk;

  seg_scan_driver_if bus_lz ();
  seg_scan_driver_if bus_nlz ();

  assign bus_lz.value  = value;
  assign bus_lz.en     = en;
  assign bus_nlz.value = value;
  assign bus_nlz.en    = en;

  seg_scan_driver #(.TICKS_PER_DIGIT(T), .LZ_BLANK(1'b1)) dut_lz (
    .clk (clk),
    .rst (rst),
    .bus (bus_lz)
  );

  seg_scan_driver #(.TICKS_PER_DIGIT(T), .LZ_BLANK(1'b0)) dut_nlz (
    .clk (clk),
    .rst (rst),
    .bus (bus_nlz)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q2[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  int          m_n;
  int          m_cap;
  int          m_slot;
  logic [19:0] m_disp_lz;
  logic [19:0] m_disp_nlz;
  logic [3:0]  m_an;
  logic        m_busy;

  localparam logic [19:0] DISP_RESET = {5'd16, 5'd16, 5'd16, 5'd0};

  // Digits of v in decimal; digit k is a leading zero exactly when v < 10^k.
  function automatic logic [19:0] render(input int v, input bit lz);
    logic [19:0] r;
    int          p;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      if (v > 9999)                 r[5*k +: 5] = 5'd17;
      else if (lz && k > 0 && v < p) r[5*k +: 5] = 5'd16;
      else                          r[5*k +: 5] = 5'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_n        = 0;
      m_disp_lz  = DISP_RESET;
      m_disp_nlz = DISP_RESET;
      exp_q.push_back({1'b0, 4'b1111, 5'd16});
      exp_q2.push_back({1'b0, 4'b1111, 5'd16});
    end else begin
      m_slot = (m_n / T) % 4;
      m_an   = 4'b0001 << m_slot;
      m_busy = ((m_n % PERIOD) != PERIOD - 1);
      if (en) begin
        exp_q.push_back({m_busy, ~m_an, m_disp_lz[5*m_slot +: 5]});
        exp_q2.push_back({m_busy, ~m_an, m_disp_nlz[5*m_slot +: 5]});
      end else begin
        exp_q.push_back({m_busy, 4'b1111, 5'd16});
        exp_q2.push_back({m_busy, 4'b1111, 5'd16});
      end
      if ((m_n % PERIOD) == 0) m_cap = int'(value);
      if ((m_n % PERIOD) == PERIOD - 1) begin
        m_disp_lz  = render(m_cap, 1'b1);
        m_disp_nlz = render(m_cap, 1'b0);
      end
      m_n = m_n + 1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: busy/an/digit got %0b/%b/%0d expected %0b/%b/%0d",
               name, $time, got[9], got[8:5], got[4:0], exp[9], exp[8:5], exp[4:0]);
    end
  endtask

  logic [W-1:0] e1;
  logic [W-1:0] e2;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e1 = exp_q.pop_front();
      check("lz_blank_on", {bus_lz.busy, bus_lz.an, bus_lz.digit_holder}, e1);
    end
    if (exp_q2.size() > 0) begin
      e2 = exp_q2.pop_front();
      check("lz_blank_off", {bus_nlz.busy, bus_nlz.an, bus_nlz.digit_holder}, e2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int p);
    int guard;
    guard = 0;
    while (((m_n % PERIOD) != p) && (guard < 2 * PERIOD)) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int sel;

  initial begin
    rst   = 1'b1;
    value = 16'd0;
    en    = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(40);

    value = 16'd2048;  cycles(60);
    value = 16'd7;     cycles(60);
    value = 16'd10000; cycles(40);
    value = 16'd65535; cycles(40);
    value = 16'd9999;  cycles(60);

    // Value change while a conversion is in its shift phase.
    wait_phase(0);
    value = 16'd512;
    cycles(5);
    value = 16'd64;
    cycles(60);

    // Enable dropped and restored in the middle of a slot.
    wait_phase(2);
    en = 1'b0;
    cycles(3);
    en = 1'b1;
    cycles(20);

    // Reset in the middle of a conversion.
    value = 16'd1234;
    wait_phase(8);
    apply_reset(2);
    cycles(60);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: value = 16'($urandom_range(0, 99));
        1: value = 16'($urandom_range(0, 9999));
        2: value = 16'($urandom_range(10000, 65535));
        default: value = 16'($urandom_range(0, 65535));
      endcase
      en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 29) == 0) apply_reset($urandom_range(1, 3));
      cycles($urandom_range(1, 40));
    end

    en = 1'b1;
    cycles(40);
    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
